input_debounce4: RTL and testbench
==================================

// Module: input_debounce4
// PURPOSE
//   Four-channel synchronizer and debouncer for raw switch/button inputs.
//   Sits directly upstream of the AND-OR-INVERT gate stage.
//   clean_out[0..3] drive that stage's a, b, c, d inputs.
//   Also flags per-channel edge events for downstream logging/counting.
// PARAMETERS
//   SYNC_STAGES    2      synchronizer flop depth per channel; legal 2..3
//   CNT_W          16     width of per-channel stability counter
//   STABLE_CYCLES  1000   consecutive mismatch cycles required to flip; 1 <= value < 2**CNT_W
//   INIT_VAL       1'b0   reset value of synchronizer flops and clean_out (all channels)
// PORTS
//   clk        in   1   single clock; all state updates on posedge
//   reset      in   1   synchronous, active-high
//   raw_in     in   4   asynchronous raw inputs; bit0=a, bit1=b, bit2=c, bit3=d
//   clean_out  out  4   debounced level per channel -> gate stage a..d
//   rise       out  4   one-cycle pulse when clean_out[i] goes 0->1
//   fall       out  4   one-cycle pulse when clean_out[i] goes 1->0
//   changed    out  1   registered OR of (rise|fall); high in same cycle as the pulses
// BEHAVIOUR
//   Reset: sync flops=INIT_VAL, clean_out={4{INIT_VAL}}, cnt=0, state=S_STABLE.
//     rise=fall=0, changed=0. Reset has priority over all other logic.
//   Synchronizer: raw_in[i] passes through SYNC_STAGES flops; s[i] = last stage.
//   Per-channel FSM, updated every clk:
//     S_STABLE: if s!=clean_out -> cnt<=1, go S_CHANGING.
//       If STABLE_CYCLES==1, instead flip clean_out immediately and stay in S_STABLE.
//     S_CHANGING, s==clean_out: glitch rejected; cnt<=0, go S_STABLE, no pulse.
//     S_CHANGING, s!=clean_out, cnt==STABLE_CYCLES-1: flip clean_out, cnt<=0, go S_STABLE.
//     S_CHANGING, otherwise: cnt<=cnt+1.
//   Latency: SYNC_STAGES+STABLE_CYCLES cycles from the edge that first samples a
//     new raw level (held stable) to the edge that updates clean_out.
//   rise/fall/changed are registered on the same edge as the clean_out flip.
//     They are high for exactly one cycle. rise and fall are never both high on one channel.
//   Counter never wraps: the flip threshold is reached before overflow.
//   Channels are fully independent; simultaneous flips on several channels give
//     multi-bit rise/fall in the same cycle.
//   Reset mid-count discards progress: no flip and no pulse. After release, a
//     raw!=INIT_VAL input debounces from scratch.
//   Pulses are never generated by reset itself, even if clean_out changes value.
// STRUCTURE
//   Shared header debounce_defs.vh holds:
//     state encodings S_STABLE=1'b0, S_CHANGING=1'b1
//     default parameter values
//   Sub-module debounce_ch: one channel = synchronizer + FSM + counter + edge pulses.
//     Instantiated 4x via generate.
//   Top level also ORs the pulses into changed (registered).
// TESTING (SYNC_STAGES=2, STABLE_CYCLES=4, INIT_VAL=0)
//   1 Reset: raw_in=4'hF, reset=1 for 3 cycles -> clean_out=0, rise=fall=0, changed=0
//     throughout; clean_out[*] first goes 1 six cycles after release.
//   2 Single rise: raw_in[0] 0->1 and held -> clean_out[0]=1 exactly 6 cycles later.
//     rise[0]=1 and changed=1 for that one cycle only.
//   3 Glitch: raw_in[1] high 3 cycles, then low -> clean_out[1] stays 0; no rise/fall/changed.
//   4 Bounce: raw_in[2] = 1,0,1,1,1,1,1... -> clean_out[2] flips only after 4 consecutive
//     synced 1s, i.e. 6 cycles after the last 0->1 transition.
//   5 Simultaneous: raw_in=4'b1010 held -> rise=4'b1010 in one cycle.
//     Then raw_in=0 -> fall=4'b1010 in one cycle; changed=1 each time.
//   6 Reset mid-count: raw_in[3]=1; reset for 1 cycle at count 2 -> no flip/pulse.
//     clean_out[3]=1 six cycles after release.

Source files
------------

// File: rtl/input_debounce4_pkg.sv
// Shared state encoding and default parameters for the four-channel input debouncer.
package input_debounce4_pkg;

    typedef enum logic {
        S_STABLE   = 1'b0,
        S_CHANGING = 1'b1
    } ch_state_e;

    localparam int  DEF_SYNC_STAGES   = 2;
    localparam int  DEF_CNT_W         = 16;
    localparam int  DEF_STABLE_CYCLES = 1000;
    localparam logic DEF_INIT_VAL     = 1'b0;
    localparam int  NUM_CH            = 4;

endpackage

// File: rtl/input_debounce4_debounce_ch.sv
// One debounce channel: synchronizer, stability FSM with counter, and edge pulses.
module debounce_ch
    import input_debounce4_pkg::*;
#(
    parameter int   SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int   CNT_W         = DEF_CNT_W,
    parameter int   STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter logic INIT_VAL      = DEF_INIT_VAL
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic clean,
    output logic rise,
    output logic fall,
    output logic pulse_next
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   s;
    ch_state_e              state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic                   clean_reg, clean_next;
    logic                   rise_reg, fall_reg;
    logic                   flip;

    assign s = sync_reg[SYNC_STAGES-1];

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        flip       = 1'b0;
        case (state_reg)
            S_STABLE: begin
                if (s != clean_reg) begin
                    // A threshold of one leaves no room for a counting phase.
                    if (STABLE_CYCLES == 1) begin
                        flip = 1'b1;
                    end else begin
                        cnt_next   = CNT_W'(1);
                        state_next = S_CHANGING;
                    end
                end
            end
            S_CHANGING: begin
                if (s == clean_reg) begin
                    cnt_next   = '0;
                    state_next = S_STABLE;
                end else if (cnt_reg == LAST_CNT) begin
                    flip       = 1'b1;
                    cnt_next   = '0;
                    state_next = S_STABLE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = S_STABLE;
            end
        endcase
        clean_next = clean_reg ^ flip;
    end

    assign pulse_next = flip;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg  <= {SYNC_STAGES{INIT_VAL}};
            state_reg <= S_STABLE;
            cnt_reg   <= '0;
            clean_reg <= INIT_VAL;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[SYNC_STAGES-2:0], raw};
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            clean_reg <= clean_next;
            rise_reg  <= flip & ~clean_reg;
            fall_reg  <= flip & clean_reg;
        end
    end

    assign clean = clean_reg;
    assign rise  = rise_reg;
    assign fall  = fall_reg;

endmodule

// File: rtl/input_debounce4.sv
// Four independent debounce channels feeding the AOI gate stage, plus a combined change flag.
module input_debounce4
    import input_debounce4_pkg::*;
#(
    parameter int   SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int   CNT_W         = DEF_CNT_W,
    parameter int   STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter logic INIT_VAL      = DEF_INIT_VAL
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] raw_in,
    output logic [NUM_CH-1:0] clean_out,
    output logic [NUM_CH-1:0] rise,
    output logic [NUM_CH-1:0] fall,
    output logic              changed
);

    logic [NUM_CH-1:0] pulse_next;
    logic              changed_reg;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            debounce_ch #(
                .SYNC_STAGES  (SYNC_STAGES),
                .CNT_W        (CNT_W),
                .STABLE_CYCLES(STABLE_CYCLES),
                .INIT_VAL     (INIT_VAL)
            ) u_ch (
                .clk       (clk),
                .reset     (reset),
                .raw       (raw_in[gi]),
                .clean     (clean_out[gi]),
                .rise      (rise[gi]),
                .fall      (fall[gi]),
                .pulse_next(pulse_next[gi])
            );
        end
    endgenerate

    // Built from the channels' pre-register flip terms so it lines up with rise/fall.
    always_ff @(posedge clk) begin
        if (reset) begin
            changed_reg <= 1'b0;
        end else begin
            changed_reg <= |pulse_next;
        end
    end

    assign changed = changed_reg;

endmodule

// File: tb/tb_input_debounce4.sv
// Randomized and directed checks of input_debounce4 against a run-length reference model.
module tb_input_debounce4;

    localparam int   SYNC   = 2;
    localparam int   STABLE = 4;
    localparam logic INITV  = 1'b0;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] raw_in;
    logic [3:0] clean_out, rise, fall;
    logic       changed;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Reference model: synced samples delayed by SYNC edges, flip after STABLE mismatches in a row.
    logic [3:0] m_pipe[$];
    logic [3:0] m_clean, m_rise, m_fall;
    logic       m_changed;
    int         m_run[4];

    input_debounce4 #(
        .SYNC_STAGES  (SYNC),
        .CNT_W        (16),
        .STABLE_CYCLES(STABLE),
        .INIT_VAL     (INITV)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .raw_in   (raw_in),
        .clean_out(clean_out),
        .rise     (rise),
        .fall     (fall),
        .changed  (changed)
    );

    always #5 clk = ~clk;

    task automatic model_edge();
        logic [3:0] s;
        if (reset) begin
            m_pipe.delete();
            for (int k = 0; k < SYNC; k++) m_pipe.push_back({4{INITV}});
            m_clean   = {4{INITV}};
            m_rise    = 4'b0;
            m_fall    = 4'b0;
            m_changed = 1'b0;
            for (int c = 0; c < 4; c++) m_run[c] = 0;
        end else begin
            s = m_pipe.pop_front();
            m_pipe.push_back(raw_in);
            m_rise = 4'b0;
            m_fall = 4'b0;
            for (int c = 0; c < 4; c++) begin
                if (s[c] != m_clean[c]) begin
                    m_run[c]++;
                    if (m_run[c] == STABLE) begin
                        if (m_clean[c]) m_fall[c] = 1'b1;
                        else            m_rise[c] = 1'b1;
                        m_clean[c] = ~m_clean[c];
                        m_run[c]   = 0;
                    end
                end else begin
                    m_run[c] = 0;
                end
            end
            m_changed = |(m_rise | m_fall);
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        raw_in = 4'hF;
        reset  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total_cnt++;
            if ({clean_out, rise, fall, changed} !== 13'h0) begin
                $display("FAIL reset_hold cyc%0d: got clean=%h rise=%h fall=%h chg=%b required all 0",
                         i, clean_out, rise, fall, changed);
            end else pass_cnt++;
        end
        reset = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            total_cnt++;
            if (clean_out !== ((i >= 6) ? 4'hF : 4'h0) || rise !== ((i == 6) ? 4'hF : 4'h0)
                || changed !== (i == 6)) begin
                $display("FAIL reset_release cyc%0d: got clean=%h rise=%h chg=%b", i, clean_out, rise, changed);
            end else pass_cnt++;
        end
        raw_in = 4'h0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            total_cnt++;
            if (clean_out !== ((i >= 6) ? 4'h0 : 4'hF) || fall !== ((i == 6) ? 4'hF : 4'h0)) begin
                $display("FAIL reset_fall cyc%0d: got clean=%h fall=%h", i, clean_out, fall);
            end else pass_cnt++;
        end
    endtask

    task automatic test_single_rise();
        raw_in = 4'b0001;
        for (int i = 1; i <= 8; i++) begin
            tick();
            total_cnt++;
            if (clean_out !== ((i >= 6) ? 4'b0001 : 4'b0000) || rise !== ((i == 6) ? 4'b0001 : 4'b0000)
                || fall !== 4'b0 || changed !== (i == 6)) begin
                $display("FAIL single_rise cyc%0d: got clean=%h rise=%h fall=%h chg=%b",
                         i, clean_out, rise, fall, changed);
            end else pass_cnt++;
        end
        raw_in = 4'b0000;
        repeat (8) tick();
        total_cnt++;
        if (clean_out !== 4'b0) begin
            $display("FAIL single_rise_return: got clean=%h required 0", clean_out);
        end else pass_cnt++;
    endtask

    task automatic test_glitch();
        raw_in = 4'b0010;
        for (int i = 1; i <= 12; i++) begin
            if (i == 4) raw_in = 4'b0000;
            tick();
            total_cnt++;
            if ({clean_out, rise, fall, changed} !== 13'h0) begin
                $display("FAIL glitch cyc%0d: got clean=%h rise=%h fall=%h chg=%b required all 0",
                         i, clean_out, rise, fall, changed);
            end else pass_cnt++;
        end
    endtask

    task automatic test_bounce();
        logic [2:0] pat;
        pat = 3'b101;
        for (int i = 1; i <= 10; i++) begin
            raw_in = (i <= 3) ? {1'b0, pat[i-1], 2'b00} : 4'b0100;
            tick();
            total_cnt++;
            if (clean_out !== ((i >= 8) ? 4'b0100 : 4'b0000) || rise !== ((i == 8) ? 4'b0100 : 4'b0000)) begin
                $display("FAIL bounce cyc%0d: got clean=%h rise=%h", i, clean_out, rise);
            end else pass_cnt++;
        end
        raw_in = 4'b0000;
        repeat (8) tick();
    endtask

    task automatic test_simultaneous();
        raw_in = 4'b1010;
        for (int i = 1; i <= 7; i++) begin
            tick();
            total_cnt++;
            if (rise !== ((i == 6) ? 4'b1010 : 4'b0000) || changed !== (i == 6)) begin
                $display("FAIL simul_rise cyc%0d: got rise=%h chg=%b", i, rise, changed);
            end else pass_cnt++;
        end
        raw_in = 4'b0000;
        for (int i = 1; i <= 7; i++) begin
            tick();
            total_cnt++;
            if (fall !== ((i == 6) ? 4'b1010 : 4'b0000) || changed !== (i == 6) || rise !== 4'b0) begin
                $display("FAIL simul_fall cyc%0d: got fall=%h rise=%h chg=%b", i, fall, rise, changed);
            end else pass_cnt++;
        end
    endtask

    task automatic test_reset_midcount();
        raw_in = 4'b1000;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total_cnt++;
        if ({clean_out, rise, fall, changed} !== 13'h0) begin
            $display("FAIL midcount_reset: got clean=%h rise=%h chg=%b required 0", clean_out, rise, changed);
        end else pass_cnt++;
        for (int i = 1; i <= 7; i++) begin
            tick();
            total_cnt++;
            if (clean_out !== ((i >= 6) ? 4'b1000 : 4'b0000) || rise !== ((i == 6) ? 4'b1000 : 4'b0000)) begin
                $display("FAIL midcount_release cyc%0d: got clean=%h rise=%h", i, clean_out, rise);
            end else pass_cnt++;
        end
        raw_in = 4'b0000;
        repeat (8) tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) raw_in = 4'($urandom());
            reset = ($urandom_range(0, 199) == 0);
            tick();
            total_cnt++;
            if ({clean_out, rise, fall, changed} !== {m_clean, m_rise, m_fall, m_changed}
                || (rise & fall) !== 4'b0) begin
                $display("FAIL random cyc%0d: got c=%h r=%h f=%h ch=%b required c=%h r=%h f=%h ch=%b",
                         i, clean_out, rise, fall, changed, m_clean, m_rise, m_fall, m_changed);
            end else pass_cnt++;
        end
        reset = 1'b0;
    endtask

    task automatic test_model_agree();
        total_cnt++;
        if ({clean_out, rise, fall, changed} !== {m_clean, m_rise, m_fall, m_changed}) begin
            $display("FAIL model_agree: got c=%h required c=%h", clean_out, m_clean);
        end else pass_cnt++;
    endtask

    initial begin
        reset  = 1'b1;
        raw_in = 4'h0;
        test_reset();
        test_model_agree();
        test_single_rise();
        test_glitch();
        test_bounce();
        test_simultaneous();
        test_model_agree();
        test_reset_midcount();
        test_random();
        test_model_agree();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
